// File: rtl/cv32e40x_pkg.sv
// Shared types for the index-to-mask builder.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } idx_mask_state_e;

endpackage

// File: rtl/cv32e40x_idx_decoder.sv
// Combinational index to one-hot decoder with a range check against LEN.
module cv32e40x_idx_decoder #(
  parameter int unsigned LEN   = 32,
  parameter int unsigned IDX_W = $clog2(LEN)
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [LEN-1:0]   onehot_o,
  output logic             in_range_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < LEN; i++) begin
      onehot_o[i] = (32'(idx_i) == i);
    end
  end

  // A power-of-two LEN covers every encodable index, so nothing can be out of range.
  if ((32'(1) << IDX_W) == LEN) begin : g_full_range
    assign in_range_o = 1'b1;
  end else begin : g_part_range
    assign in_range_o = (32'(idx_i) < LEN);
  end

endmodule

// File: rtl/cv32e40x_idx_mask_builder.sv
// Rebuilds a LEN-bit mask from a stream of bit indices, flagging duplicates and out-of-range indices.
// Optional popcount output count_o enabled by defining CV32E40X_IDX_MASK_COUNT_EN.
module cv32e40x_idx_mask_builder
  import cv32e40x_pkg::*;
#(
  parameter  int unsigned LEN   = 32,
  localparam int unsigned IDX_W = $clog2(LEN),
  localparam int unsigned CNT_W = $clog2(LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             idx_valid_i,
  input  logic             idx_last_i,
  output logic             idx_ready_o,
  input  logic             clear_i,
  output logic [LEN-1:0]   mask_o,
  output logic             mask_valid_o,
  input  logic             mask_ready_i,
  output logic             err_o,
  output logic             dup_o
`ifdef CV32E40X_IDX_MASK_COUNT_EN
  ,
  output logic [CNT_W-1:0] count_o
`endif
);

  idx_mask_state_e state_q, state_d;
  logic [LEN-1:0]  acc_q, acc_d;
  logic            err_q, err_d;
  logic            dup_q, dup_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic [LEN-1:0]  onehot;
  logic            in_range;
  logic            accept;
  logic            transfer;
`ifdef CV32E40X_IDX_MASK_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;
`endif

  cv32e40x_idx_decoder #(
    .LEN   (LEN),
    .IDX_W (IDX_W)
  ) u_decoder (
    .idx_i      (idx_i),
    .onehot_o   (onehot),
    .in_range_o (in_range)
  );

  assign accept   = idx_valid_i && ready_q;
  assign transfer = valid_q && mask_ready_i;

  // Next-state, accumulator and flag update; clear dominates any handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
    dup_d   = dup_q;
`ifdef CV32E40X_IDX_MASK_COUNT_EN
    count_d = count_q;
`endif
    if (clear_i || transfer) begin
      state_d = IDLE;
      acc_d   = '0;
      err_d   = 1'b0;
      dup_d   = 1'b0;
`ifdef CV32E40X_IDX_MASK_COUNT_EN
      count_d = '0;
`endif
    end else if (accept) begin
      if (!in_range) begin
        err_d = 1'b1;
      end else if ((acc_q & onehot) != '0) begin
        dup_d = 1'b1;
      end else begin
        acc_d = acc_q | onehot;
`ifdef CV32E40X_IDX_MASK_COUNT_EN
        count_d = count_q + CNT_W'(1);
`endif
      end
      state_d = idx_last_i ? DONE : COLLECT;
    end
    ready_d = (state_d != DONE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      err_q   <= 1'b0;
      dup_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
`ifdef CV32E40X_IDX_MASK_COUNT_EN
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      dup_q   <= dup_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
`ifdef CV32E40X_IDX_MASK_COUNT_EN
      count_q <= count_d;
`endif
    end
  end

  assign idx_ready_o  = ready_q;
  assign mask_valid_o = valid_q;
  assign mask_o       = acc_q;
  assign err_o        = err_q;
  assign dup_o        = dup_q;
`ifdef CV32E40X_IDX_MASK_COUNT_EN
  assign count_o      = count_q;
`endif

endmodule

// File: tb/tb_cv32e40x_idx_mask_builder.sv
// Directed scoreboard bench for cv32e40x_idx_mask_builder at LEN=32 and LEN=20.
module tb_cv32e40x_idx_mask_builder;

  typedef struct {
    logic [63:0] mask;
    logic        err;
    logic        dup;
    int unsigned cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // LEN = 32 instance
  logic [4:0]  idx32;
  logic        v32, last32, clr32, mrdy32;
  logic        rdy32, mv32, err32, dup32;
  logic [31:0] mask32;
  // LEN = 20 instance
  logic [4:0]  idx20;
  logic        v20, last20, clr20, mrdy20;
  logic        rdy20, mv20, err20, dup20;
  logic [19:0] mask20;
`ifdef CV32E40X_IDX_MASK_COUNT_EN
  logic [5:0]  cnt32;
  logic [4:0]  cnt20;
`endif

  cv32e40x_idx_mask_builder #(.LEN(32)) u_dut32 (
    .clk          (clk),
    .rst          (rst),
    .idx_i        (idx32),
    .idx_valid_i  (v32),
    .idx_last_i   (last32),
    .idx_ready_o  (rdy32),
    .clear_i      (clr32),
    .mask_o       (mask32),
    .mask_valid_o (mv32),
    .mask_ready_i (mrdy32),
    .err_o        (err32),
    .dup_o        (dup32)
`ifdef CV32E40X_IDX_MASK_COUNT_EN
    ,
    .count_o      (cnt32)
`endif
  );

  cv32e40x_idx_mask_builder #(.LEN(20)) u_dut20 (
    .clk          (clk),
    .rst          (rst),
    .idx_i        (idx20),
    .idx_valid_i  (v20),
    .idx_last_i   (last20),
    .idx_ready_o  (rdy20),
    .clear_i      (clr20),
    .mask_o       (mask20),
    .mask_valid_o (mv20),
    .mask_ready_i (mrdy20),
    .err_o        (err20),
    .dup_o        (dup20)
`ifdef CV32E40X_IDX_MASK_COUNT_EN
    ,
    .count_o      (cnt20)
`endif
  );

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] m, input logic e, input logic d, input int unsigned c);
    exp_t x;
    x.mask = m; x.err = e; x.dup = d; x.cnt = c;
    sb_q.push_back(x);
  endtask

  task automatic send32(input logic [4:0] i, input logic l);
    chk("rdy32_before_send", 64'(rdy32), 64'd1);
    v32 = 1'b1; idx32 = i; last32 = l;
    step();
    v32 = 1'b0; last32 = 1'b0;
  endtask

  task automatic send20(input logic [4:0] i, input logic l);
    chk("rdy20_before_send", 64'(rdy20), 64'd1);
    v20 = 1'b1; idx20 = i; last20 = l;
    step();
    v20 = 1'b0; last20 = 1'b0;
  endtask

  // Pops the oldest expected mask and compares it with the completed output of the chosen instance.
  task automatic check_done(input bit use20);
    exp_t x;
    chk("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      if (use20) begin
        chk("mv20", 64'(mv20), 64'd1);
        chk("mask20", 64'(mask20), x.mask);
        chk("err20", 64'(err20), 64'(x.err));
        chk("dup20", 64'(dup20), 64'(x.dup));
        chk("rdy20_done", 64'(rdy20), 64'd0);
`ifdef CV32E40X_IDX_MASK_COUNT_EN
        chk("cnt20", 64'(cnt20), 64'(x.cnt));
`endif
      end else begin
        chk("mv32", 64'(mv32), 64'd1);
        chk("mask32", 64'(mask32), x.mask);
        chk("err32", 64'(err32), 64'(x.err));
        chk("dup32", 64'(dup32), 64'(x.dup));
        chk("rdy32_done", 64'(rdy32), 64'd0);
`ifdef CV32E40X_IDX_MASK_COUNT_EN
        chk("cnt32", 64'(cnt32), 64'(x.cnt));
`endif
      end
    end
  endtask

  task automatic check_idle32(input string tag);
    chk({tag, "_mv"},   64'(mv32),   64'd0);
    chk({tag, "_mask"}, 64'(mask32), 64'd0);
    chk({tag, "_err"},  64'(err32),  64'd0);
    chk({tag, "_dup"},  64'(dup32),  64'd0);
    chk({tag, "_rdy"},  64'(rdy32),  64'd1);
`ifdef CV32E40X_IDX_MASK_COUNT_EN
    chk({tag, "_cnt"},  64'(cnt32),  64'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    idx32 = '0; v32 = 1'b0; last32 = 1'b0; clr32 = 1'b0; mrdy32 = 1'b0;
    idx20 = '0; v20 = 1'b0; last20 = 1'b0; clr20 = 1'b0; mrdy20 = 1'b0;
    step();
    step();
    chk("rst_mv32", 64'(mv32), 64'd0);
    chk("rst_mask20", 64'(mask20), 64'd0);
    rst = 1'b0;
    step();
    check_idle32("after_rst");
    chk("after_rst_rdy20", 64'(rdy20), 64'd1);

    // Three in-range indices, consumer always ready
    mrdy32 = 1'b1;
    send32(5'd3, 1'b0);
    chk("t1_partial_mask", 64'(mask32), 64'h8);
    chk("t1_partial_mv", 64'(mv32), 64'd0);
    send32(5'd7, 1'b0);
    push_exp(64'h8000_0088, 1'b0, 1'b0, 3);
    send32(5'd31, 1'b1);
    check_done(1'b0);
    step();
    check_idle32("t1_after_xfer");

    // Duplicate index on the last beat
    send32(5'd4, 1'b0);
    push_exp(64'h10, 1'b0, 1'b1, 1);
    send32(5'd4, 1'b1);
    check_done(1'b0);
    step();
    check_idle32("t2_after_xfer");

    // Backpressure in DONE with a pending index on the input
    mrdy32 = 1'b0;
    send32(5'd1, 1'b0);
    push_exp(64'h22, 1'b0, 1'b0, 2);
    send32(5'd5, 1'b1);
    check_done(1'b0);
    v32 = 1'b1; idx32 = 5'd9; last32 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t3_hold_rdy", 64'(rdy32), 64'd0);
      chk("t3_hold_mask", 64'(mask32), 64'h22);
      chk("t3_hold_mv", 64'(mv32), 64'd1);
    end
    mrdy32 = 1'b1;
    step();
    v32 = 1'b0;
    check_idle32("t3_after_xfer");
    push_exp(64'h200, 1'b0, 1'b0, 1);
    send32(5'd9, 1'b1);
    check_done(1'b0);
    step();
    check_idle32("t3_second_xfer");

    // Clear coincident with the last accept drops the mask
    send32(5'd2, 1'b0);
    send32(5'd9, 1'b0);
    chk("t4_partial_mask", 64'(mask32), 64'h204);
    clr32 = 1'b1;
    send32(5'd12, 1'b1);
    clr32 = 1'b0;
    check_idle32("t4_after_clear");
    step();
    chk("t4_no_valid", 64'(mv32), 64'd0);

    // Reset in the middle of a mask
    send32(5'd1, 1'b0);
    send32(5'd2, 1'b0);
    chk("t5_partial_mask", 64'(mask32), 64'h6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle32("t5_after_rst");
    push_exp(64'h1, 1'b0, 1'b0, 1);
    send32(5'd0, 1'b1);
    check_done(1'b0);
    step();
    check_idle32("t5_after_xfer");

    // LEN=20: out-of-range last index still completes the mask
    mrdy20 = 1'b1;
    send20(5'd5, 1'b0);
    chk("t6_partial_mask", 64'(mask20), 64'h20);
    chk("t6_partial_err", 64'(err20), 64'd0);
    push_exp(64'h20, 1'b1, 1'b0, 1);
    send20(5'd25, 1'b1);
    check_done(1'b1);
    step();
    chk("t6_after_xfer_mask", 64'(mask20), 64'd0);
    chk("t6_after_xfer_err", 64'(err20), 64'd0);
    chk("t6_after_xfer_rdy", 64'(rdy20), 64'd1);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
